// File: rtl/async_event_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// async_event_arbiter_pkg
// Shared definitions for the asynchronous event arbiter:
//   - arb_state_t   : scheduler state encoding (IDLE=0, OFFER=1)
//   - WARMUP_CYCLES : cycles after reset during which debounced levels simply
//                     track the synchronizer, so levels held through reset
//                     never look like fresh edges
//   - warmup_next   : saturating down-count helper for the warm-up counter
// ----------------------------------------------------------------------------
package async_event_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } arb_state_t;

    localparam int WARMUP_CYCLES = 2;
    localparam int WARMUP_W      = 2;

    // Count down to zero and stay there.
    function automatic logic [WARMUP_W-1:0] warmup_next(input logic [WARMUP_W-1:0] cnt);
        logic [WARMUP_W-1:0] nxt;
        if (cnt == WARMUP_W'(1'b0)) begin
            nxt = cnt;
        end else begin
            nxt = cnt - WARMUP_W'(1'b1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/async_event_arbiter_sync_debounce_ch.sv
// ----------------------------------------------------------------------------
// sync_debounce_ch
// One input channel: 2-flop synchronizer (no reset), debounce counter and
// debounced level register. Emits a one-cycle pulse on the cycle the
// debounced level changes.
// Optional build macro: ASYNC_EVT_BOTH_EDGES_EN adds the o_fall pulse port.
// Ports:
//   clk      in   system clock
//   reset    in   synchronous active-high reset
//   i_async  in   raw asynchronous input
//   i_warm   in   warm-up active: debounced level tracks synchronizer directly
//   o_rise   out  combinational pulse, debounced level going 0->1 this cycle
//   o_fall   out  combinational pulse, debounced level going 1->0 this cycle
// ----------------------------------------------------------------------------
module sync_debounce_ch
    import async_event_arbiter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    input  logic i_warm,
    output logic o_rise
`ifdef ASYNC_EVT_BOTH_EDGES_EN
    ,
    output logic o_fall
`endif
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_deb;
    logic [CW-1:0] r_cnt;
    logic          w_fire;

    // Synchronizer stages keep shifting during reset so the level is valid at warm-up.
    always_ff @(posedge clk) begin
        r_sync1 <= i_async;
        r_sync2 <= r_sync1;
    end

    // Level change commits on the last stable cycle of the debounce window.
    assign w_fire = !i_warm && (r_sync2 != r_deb) && (r_cnt == CNT_MAX);

    // Debounce counter and debounced level.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_deb <= 1'b0;
            r_cnt <= CW'(1'b0);
        end else if (i_warm) begin
            r_deb <= r_sync2;
            r_cnt <= CW'(1'b0);
        end else if (r_sync2 == r_deb) begin
            r_cnt <= CW'(1'b0);
        end else if (r_cnt == CNT_MAX) begin
            r_deb <= r_sync2;
            r_cnt <= CW'(1'b0);
        end else begin
            r_cnt <= r_cnt + CW'(1'b1);
        end
    end

    assign o_rise = w_fire & r_sync2;
`ifdef ASYNC_EVT_BOTH_EDGES_EN
    assign o_fall = w_fire & ~r_sync2;
`endif

endmodule

// File: rtl/async_event_arbiter.sv
// ----------------------------------------------------------------------------
// async_event_arbiter
// Synchronizes and debounces N asynchronous inputs, latches detected edges as
// pending events and offers them one at a time on a valid/ready port using a
// round-robin scheduler.
// Optional build macro: ASYNC_EVT_BOTH_EDGES_EN -- debounced falling edges
// also raise events (same overflow rule). Ports and latency are unchanged.
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-high reset
//   async_in   in   [N_INPUTS]  raw asynchronous inputs
//   evt_valid  out  event offered (held until evt_ready)
//   evt_ready  in   consumer accepts the event
//   evt_id     out  [IDW]  channel index of the offered event
//   pending    out  [N_INPUTS]  per-channel pending flags
//   overflow   out  sticky: an event was lost
// ----------------------------------------------------------------------------
module async_event_arbiter
    import async_event_arbiter_pkg::*;
#(
    parameter  int N_INPUTS        = 4,
    parameter  int DEBOUNCE_CYCLES = 16,
    localparam int IDW             = $clog2(N_INPUTS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_INPUTS-1:0] async_in,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [IDW-1:0]      evt_id,
    output logic [N_INPUTS-1:0] pending,
    output logic                overflow
);

    logic [WARMUP_W-1:0] r_warm;
    logic                w_warm;
    logic [N_INPUTS-1:0] w_rise;
    logic [N_INPUTS-1:0] w_ev;
    logic                w_handshake;

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic                r_evt_valid;
    logic                w_valid_nxt;
    logic [IDW-1:0]      r_evt_id;
    logic [IDW-1:0]      w_id_nxt;
    logic [IDW-1:0]      r_rr_ptr;
    logic [IDW-1:0]      w_ptr_nxt;
    logic [N_INPUTS-1:0] r_pending;
    logic [N_INPUTS-1:0] w_pending_nxt;
    logic                r_overflow;
    logic                w_ovf_nxt;

    // First set request scanning upward from ptr, wrapping.
    function automatic logic [IDW-1:0] rr_select(input logic [N_INPUTS-1:0] req,
                                                 input logic [IDW-1:0]      ptr);
        logic [IDW-1:0] sel;
        int             idx;
        sel = ptr;
        // Descending scan so the closest request to ptr is written last.
        for (int k = N_INPUTS - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N_INPUTS;
            if (req[idx]) begin
                sel = IDW'(idx);
            end else begin
                sel = sel;
            end
        end
        return sel;
    endfunction

    assign w_warm = (r_warm != WARMUP_W'(1'b0));

    for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_ch
`ifdef ASYNC_EVT_BOTH_EDGES_EN
        logic w_fall;
        sync_debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
            .clk     (clk),
            .reset   (reset),
            .i_async (async_in[gi]),
            .i_warm  (w_warm),
            .o_rise  (w_rise[gi]),
            .o_fall  (w_fall)
        );
        assign w_ev[gi] = w_rise[gi] | w_fall;
`else
        sync_debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
            .clk     (clk),
            .reset   (reset),
            .i_async (async_in[gi]),
            .i_warm  (w_warm),
            .o_rise  (w_rise[gi])
        );
        assign w_ev[gi] = w_rise[gi];
`endif
    end

    assign w_handshake = (r_state == OFFER) && evt_ready;

    // Pending set/clear; an event on the channel being cleared re-arms it without loss.
    always_comb begin
        logic w_clr;
        w_pending_nxt = r_pending;
        w_ovf_nxt     = r_overflow;
        w_clr         = 1'b0;
        for (int i = 0; i < N_INPUTS; i++) begin
            w_clr = w_handshake && (r_evt_id == IDW'(i));
            if (w_ev[i]) begin
                if (r_pending[i] && !w_clr) begin
                    w_ovf_nxt = 1'b1;
                end else begin
                    w_ovf_nxt = w_ovf_nxt;
                end
                w_pending_nxt[i] = 1'b1;
            end else if (w_clr) begin
                w_pending_nxt[i] = 1'b0;
            end else begin
                w_pending_nxt[i] = r_pending[i];
            end
        end
    end

    // Scheduler next-state and next outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_evt_valid;
        w_id_nxt    = r_evt_id;
        w_ptr_nxt   = r_rr_ptr;
        case (r_state)
            IDLE: begin
                if (r_pending != {N_INPUTS{1'b0}}) begin
                    w_state_nxt = OFFER;
                    w_valid_nxt = 1'b1;
                    w_id_nxt    = rr_select(r_pending, r_rr_ptr);
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            OFFER: begin
                if (evt_ready) begin
                    w_state_nxt = IDLE;
                    w_valid_nxt = 1'b0;
                    if (r_evt_id == IDW'(N_INPUTS - 1)) begin
                        w_ptr_nxt = IDW'(1'b0);
                    end else begin
                        w_ptr_nxt = r_evt_id + IDW'(1'b1);
                    end
                end else begin
                    w_state_nxt = OFFER;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // State, scheduler outputs, pending flags and warm-up counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_warm      <= WARMUP_W'(WARMUP_CYCLES);
            r_state     <= IDLE;
            r_evt_valid <= 1'b0;
            r_evt_id    <= IDW'(1'b0);
            r_rr_ptr    <= IDW'(1'b0);
            r_pending   <= {N_INPUTS{1'b0}};
            r_overflow  <= 1'b0;
        end else begin
            r_warm      <= warmup_next(r_warm);
            r_state     <= w_state_nxt;
            r_evt_valid <= w_valid_nxt;
            r_evt_id    <= w_id_nxt;
            r_rr_ptr    <= w_ptr_nxt;
            r_pending   <= w_pending_nxt;
            r_overflow  <= w_ovf_nxt;
        end
    end

    assign evt_valid = r_evt_valid;
    assign evt_id    = r_evt_id;
    assign pending   = r_pending;
    assign overflow  = r_overflow;

endmodule
